multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle RISC-V datapath. It decodes `op`, sequences the datapath through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It produces `ALUOp` for the ALU-control decoder, which is the downstream consumer. Supported instructions: lw, sw, R-type, addi, beq, jal. Any other opcode halts the core.

## Interface
- No parameters.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — synchronous, active-high reset.
- `op` in 7 — instruction opcode, taken from the instruction register (IR[6:0]).
- `zero` in 1 — ALU zero flag, valid in the cycle it is consumed.
- `PCWrite` out 1 — PC register enable.
- `AdrSrc` out 1 — memory address select: 0=PC, 1=ALUOut.
- `MemWrite` out 1 — data memory write enable.
- `IRWrite` out 1 — IR and OldPC enable.
- `ResultSrc` out 2 — result select: 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 2 — ALU source A: 00=PC, 01=OldPC, 10=A register.
- `ALUSrcB` out 2 — ALU source B: 00=B register, 01=ImmExt, 10=constant 4.
- `ImmSrc` out 2 — immediate type: 00=I, 01=S, 10=B, 11=J.
- `RegWrite` out 1 — register file write enable.
- `ALUOp` out 2 — to ALU control: 00=add, 01=sub, 10=use funct fields.
- `retire` out 1 — one-cycle pulse in the final state of each instruction.
- `halt` out 1 — high while in TRAP.
- `instr_count` out 32 — retired-instruction count. Present only with `MC_INSTR_COUNT_EN`.

## Operation
**States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.

**Transitions:**
- FETCH → DECODE.
- DECODE, by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - any other opcode → TRAP.
- MEMADR → MEMREAD if lw, else MEMWR.
- MEMREAD → MEMWB.
- EXECR, EXECI, JAL → ALUWB.
- MEMWB, MEMWR, ALUWB, BEQ → FETCH.
- TRAP → TRAP, until `rst`.

**Moore outputs per state.** Every output not listed is 0.
- FETCH: `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, `ResultSrc`=10, `ALUOp`=00, `PCWrite`=1.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00. Precomputes the branch/jump target.
- MEMADR, EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
- MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, `retire`=1.
- MEMWR: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1, `retire`=1.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, `retire`=1.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `retire`=1, `PCWrite`=`zero`. This is the only Mealy term.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1.
- TRAP: `halt`=1.

**`ImmSrc`:** combinational from `op` in every state.
- lw / addi → 00; sw → 01; beq → 10; jal → 11.
- Any other opcode → 00.

**Reset:**
- While `rst`=1, all outputs are forced to 0 regardless of state.
- The next edge with `rst` high loads FETCH.
- Reset during any state, including TRAP or mid-instruction, aborts the instruction with no further write enables asserted.

## Timing
- Cycles per instruction, counted from FETCH: lw 5; sw 4; R-type 4; addi 4; jal 4; beq 3.
- The state register updates on the rising edge. Outputs are valid in the same cycle as the state.
- `zero` is sampled combinationally in BEQ only. A `zero` glitch in any other state has no effect.
- An unsupported opcode reaches TRAP 2 cycles after FETCH. No write enable asserts after leaving DECODE.

## Configuration
- `MC_INSTR_COUNT_EN` defined:
  - `instr_count` is a 32-bit register, cleared by `rst`.
  - It increments on every clock edge where `retire`=1 and wraps 0xFFFFFFFF → 0.
  - It holds its value in TRAP.
- `MC_INSTR_COUNT_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode localparams;
  - `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ImmSrc` and `ALUOp` encodings.
- Sub-module `imm_src_decoder`: combinational, `op` → `ImmSrc`. It is instantiated once.

## Test plan
- Reset, then an lw opcode: visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `RegWrite`=1 in cycle 5 only, `retire` pulses once.
- R-type followed by sw: `ALUOp`=10 in EXECR. `MemWrite`=1 exactly once, in cycle 4 of sw, with `AdrSrc`=1.
- beq twice, with `zero`=1 then `zero`=0: `PCWrite`=1 in BEQ only for the first. Each takes 3 cycles with `ALUOp`=01.
- jal: `ImmSrc`=11 in DECODE, `PCWrite`=1 in JAL, `RegWrite`=1 in ALUWB; 4 cycles total.
- `op`=0x7F: TRAP after DECODE, `halt`=1 held for 20 cycles with all enables 0. Asserting `rst` returns to FETCH.
- `rst` asserted in MEMADR: no `MemWrite` or `RegWrite`. With `MC_INSTR_COUNT_EN` defined, `instr_count`=0 after reset and equals 3 after lw, sw, beq.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle control FSM: state enum, opcodes, mux/ALUOp encodings
// and the per-state control word (Moore values only; the branch PC enable is resolved by the top).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       retire;
        logic       halt;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.alu_op     = ALUOP_ADD;
                c.pc_write   = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_EXECI: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_REG;
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.retire     = 1'b1;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_TRAP: c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode -> immediate-format select; zero latency, no backpressure.
// Unknown opcodes fall back to the I-type format.
module imm_src_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_ADDI: imm_src = IMM_I;
            OP_SW:          imm_src = IMM_S;
            OP_BEQ:         imm_src = IMM_B;
            OP_JAL:         imm_src = IMM_J;
            default:        imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: outputs valid in the cycle of the state, no backpressure.
// Optional retired-instruction counter enabled by MC_INSTR_COUNT_EN.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic        zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic        retire,
    output logic        halt
`ifdef MC_INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [1:0] imm_src;
    logic       run;

    function automatic state_t next_state(state_t s, logic [6:0] opc);
        state_t n;
        n = s;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = S_EXECR;
                    OP_ADDI:      n = S_EXECI;
                    OP_BEQ:       n = S_BEQ;
                    OP_JAL:       n = S_JAL;
                    default:      n = S_TRAP;
                endcase
            end
            S_MEMADR:  n = (opc == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: n = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL:         n = S_ALUWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ: n = S_FETCH;
            S_TRAP:    n = S_TRAP;
            default:   n = S_FETCH;
        endcase
        return n;
    endfunction

    assign state_nxt = next_state(state, op);

    // Control word is registered alongside the state so each output is a flop in its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt);
        end
    end

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

    // Reset masks every output immediately, even before the reset edge lands.
    assign run       = ~rst;
    assign PCWrite   = run & (ctrl_q.pc_write | (ctrl_q.branch & zero));
    assign AdrSrc    = run & ctrl_q.adr_src;
    assign MemWrite  = run & ctrl_q.mem_write;
    assign IRWrite   = run & ctrl_q.ir_write;
    assign ResultSrc = {2{run}} & ctrl_q.result_src;
    assign ALUSrcA   = {2{run}} & ctrl_q.alu_src_a;
    assign ALUSrcB   = {2{run}} & ctrl_q.alu_src_b;
    assign ImmSrc    = {2{run}} & imm_src;
    assign RegWrite  = run & ctrl_q.reg_write;
    assign ALUOp     = {2{run}} & ctrl_q.alu_op;
    assign retire    = run & ctrl_q.retire;
    assign halt      = run & ctrl_q.halt;

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = run ? count_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller; per-cycle expectations come from
// an instruction/cycle-index model and are checked by an independent negedge monitor.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, halt;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] AI = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic       rw;
        logic [1:0] aluop;
        logic       ret, hlt;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mx;
    outs_t       act;
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    int          retire_seen = 0;
    int          retire_model = 0;
    logic [31:0] model_cnt = 0;
    logic [6:0]  valid_ops[6];
    logic [6:0]  bad_ops[6];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .zero      (zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .ALUOp     (ALUOp),
        .retire    (retire),
        .halt      (halt)
`ifdef MC_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegWrite, ALUOp, retire, halt};

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    // Cycles per instruction from FETCH; 0 marks an opcode that never completes.
    function automatic int len_of(logic [6:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RT || o == AI || o == JL) return 4;
        if (o == BQ) return 3;
        return 0;
    endfunction

    // Expected outputs for cycle c (0 = fetch) of an instruction with opcode o.
    function automatic outs_t model(logic [6:0] o, int c, logic z);
        outs_t e;
        e = '0;
        e.imm = imm_of(o);
        if (c == 0) begin
            e.irw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = 1'b1;
        end else if (c == 1) begin
            e.sa = 2'b01; e.sb = 2'b01;
        end else if (len_of(o) == 0) begin
            e.hlt = 1'b1;
        end else if (c == len_of(o) - 1 && o != BQ) begin
            e.ret = 1'b1;
            if (o == SW) begin
                e.adr = 1'b1; e.mw = 1'b1;
            end else begin
                e.rw = 1'b1;
                if (o == LW) e.rs = 2'b01;
            end
        end else if (o == BQ) begin
            e.sa = 2'b10; e.aluop = 2'b01; e.ret = 1'b1; e.pcw = z;
        end else if (o == LW && c == 3) begin
            e.adr = 1'b1;
        end else if (o == RT) begin
            e.sa = 2'b10; e.aluop = 2'b10;
        end else if (o == JL) begin
            e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
        end else begin
            e.sa = 2'b10; e.sb = 2'b01;
        end
        return e;
    endfunction

    task automatic cyc(input logic r, input logic [6:0] o, input logic z, input outs_t e);
        exp_t x;
        @(posedge clk);
        #1;
        rst  = r;
        op   = o;
        zero = z;
        x.o   = r ? outs_t'(0) : e;
        x.cnt = r ? 32'd0 : model_cnt;
        exp_q.push_back(x);
        if (r) begin
            model_cnt = 0;
        end else if (e.ret) begin
            model_cnt    = model_cnt + 1;
            retire_model = retire_model + 1;
        end
    endtask

    // abort_at >= 0 asserts reset in that cycle; zsel < 0 randomizes zero every cycle.
    task automatic run_instr(input logic [6:0] o, input int abort_at, input int zsel);
        int   n;
        logic z;
        n = len_of(o);
        if (n == 0) n = abort_at + 1;
        for (int c = 0; c < n; c++) begin
            z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
            if (c == abort_at) begin
                cyc(1'b1, o, z, '0);
                break;
            end
            cyc(1'b0, o, z, model(o, c, z));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            cyc_n = cyc_n + 1;
            tests = tests + 1;
            if (act !== mx.o) begin
                fails = fails + 1;
                $display("FAIL outs cycle %0d op=%b: got %h want %h", cyc_n, op, act, mx.o);
            end
`ifdef MC_INSTR_COUNT_EN
            tests = tests + 1;
            if (instr_count !== mx.cnt) begin
                fails = fails + 1;
                $display("FAIL instr_count cycle %0d: got %0d want %0d", cyc_n, instr_count, mx.cnt);
            end
`endif
            if (retire) retire_seen = retire_seen + 1;
        end
    end

    initial begin
        int k;
        int len;
        valid_ops = '{LW, SW, RT, AI, BQ, JL};
        bad_ops   = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67, 7'h73};

        repeat (3) cyc(1'b1, 7'd0, 1'b0, '0);

        run_instr(LW, -1, -1);
        run_instr(RT, -1, -1);
        run_instr(SW, -1, -1);
        run_instr(BQ, -1, 1);
        run_instr(BQ, -1, 0);
        run_instr(JL, -1, -1);
        run_instr(AI, -1, -1);
        run_instr(7'h7F, 22, -1);
        run_instr(LW, 2, -1);
        run_instr(LW, -1, -1);
        run_instr(SW, -1, -1);
        run_instr(BQ, -1, -1);
        run_instr(SW, 2, -1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                run_instr(bad_ops[$urandom_range(0, 5)], 2 + $urandom_range(1, 6), -1);
            end else begin
                k   = $urandom_range(0, 5);
                len = len_of(valid_ops[k]);
                if ($urandom_range(0, 9) == 0)
                    run_instr(valid_ops[k], $urandom_range(0, len - 1), -1);
                else
                    run_instr(valid_ops[k], -1, -1);
            end
        end
        run_instr(RT, -1, -1);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        tests = tests + 1;
        if (retire_seen != retire_model) begin
            fails = fails + 1;
            $display("FAIL retire_total: got %0d want %0d", retire_seen, retire_model);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
